// File: rtl/pc_npc_unit_pkg.sv
// Shared definitions for the PC/nPC register block.
//   - pc_src encodings for next-nPC selection
//   - FSM state encoding
//   - default reset vector
package pc_npc_unit_pkg;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_CALL = 2'b10;
  localparam logic [1:0] PCSRC_JMPL = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_ERR = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_target_mux.sv
// Combinational next-nPC target selection.
// Ports:
//   pc           in  current PC (base for branch/call displacement)
//   npc4         in  nPC+4 from the external adder (sequential target)
//   pc_src       in  target select (seq / branch / call / jmpl)
//   branch_taken in  qualifies branch; not-taken falls through to npc4
//   disp22       in  signed branch word displacement
//   disp30       in  signed call word displacement
//   jmpl_addr    in  jmpl target from the ALU
//   target       out selected next-nPC value
//   misalign     out jmpl selected with a non-word-aligned target
module pc_target_mux
  import pc_npc_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] npc4,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [21:0] disp22,
  input  logic [29:0] disp30,
  input  logic [31:0] jmpl_addr,
  output logic [31:0] target,
  output logic        misalign
);

  logic [31:0] br_off;
  logic [31:0] call_off;

  // Word displacements scaled to bytes; call's sign bits fall off the top.
  assign br_off   = {{8{disp22[21]}}, disp22, 2'b00};
  assign call_off = {disp30, 2'b00};

  always_comb begin
    target = npc4;
    unique case (pc_src)
      PCSRC_SEQ:  target = npc4;
      PCSRC_BR:   target = branch_taken ? (pc + br_off) : npc4;
      PCSRC_CALL: target = pc + call_off;
      PCSRC_JMPL: target = jmpl_addr;
    endcase
  end

  assign misalign = (pc_src == PCSRC_JMPL) && (jmpl_addr[1:0] != 2'b00);

endmodule

// File: rtl/pc_npc_unit.sv
// SPARC-style PC/nPC register pair with delay-slot sequencing.
// Ports:
//   clk, rst      clock (rising edge), synchronous active-low reset
//   en            update enable; low stalls every register
//   npc4_in       nPC+4 returned from the external adder
//   pc_src        next-nPC select (seq / branch / call / jmpl)
//   branch_taken  branch condition result
//   disp22        branch displacement; disp30 call displacement
//   jmpl_addr     jmpl target
//   annul_req     squash the delay-slot instruction now at nPC
//   pc_out        fetch address; npc_out feeds the PC+4 adder
//   annul_out     instruction at pc_out is to be squashed
//   err           sticky misaligned-jmpl error (cleared only by reset)
module pc_npc_unit
  import pc_npc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] npc4_in,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [21:0] disp22,
  input  logic [29:0] disp30,
  input  logic [31:0] jmpl_addr,
  input  logic        annul_req,
  output logic [31:0] pc_out,
  output logic [31:0] npc_out,
  output logic        annul_out,
  output logic        err
);

  logic [31:0] pc_q;
  logic [31:0] npc_q;
  logic        annul_q;
  pc_state_e   state_q;

  logic [31:0] target;
  logic        misalign;

  pc_target_mux u_target_mux (
    .pc           (pc_q),
    .npc4         (npc4_in),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .disp22       (disp22),
    .disp30       (disp30),
    .jmpl_addr    (jmpl_addr),
    .target       (target),
    .misalign     (misalign)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC + 32'd4;
      annul_q <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (en) begin
            if (misalign) begin
              // Freeze the pair so the faulting context stays visible.
              state_q <= ST_ERR;
            end else begin
              pc_q    <= npc_q;
              npc_q   <= target;
              annul_q <= annul_req;
            end
          end
        end
        ST_ERR: begin
          // Everything holds until reset.
        end
      endcase
    end
  end

  assign pc_out    = pc_q;
  assign npc_out   = npc_q;
  assign annul_out = annul_q;
  assign err       = (state_q == ST_ERR);

endmodule

// File: doc/pc_npc_unit.md
Name: pc_npc_unit

Overview:
- SPARC-style program-counter pair (PC, nPC) register block with next-address selection.
- Consumes the PC+4 adder's result: `npc_out` drives the adder input, and the adder output returns as `npc4_in`.
- Drives instruction-memory fetch address (`pc_out`).
- Implements delay-slot sequencing, stall hold, annul flag and a misaligned-target error state.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset; nPC resets to RESET_PC+4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  update enable; 0 = stall, registers hold.
- npc4_in  in  32  nPC+4 from the PC+4 adder (combinational, same cycle).
- pc_src  in  2  00 sequential, 01 branch disp22, 10 call disp30, 11 jmpl.
- branch_taken  in  1  qualifies pc_src=01; 0 = fall through sequentially.
- disp22  in  22  branch word displacement, signed.
- disp30  in  30  call word displacement, signed.
- jmpl_addr  in  32  ALU-computed jmpl target.
- annul_req  in  1  delay-slot instruction (currently at nPC) is to be annulled.
- pc_out  out  32  current PC / fetch address.
- npc_out  out  32  current nPC, to the PC+4 adder.
- annul_out  out  1  instruction at pc_out must be squashed (treated as nop).
- err  out  1  sticky misaligned-target error.

Behaviour:
- Reset (sampled at clk edge with rst=0):
  - pc_out=RESET_PC, npc_out=RESET_PC+4, annul_out=0, err=0, state=RUN.
  - rst has priority over every other input.
- States: RUN, ERR.
  - RUN→ERR only on a misaligned jmpl.
  - ERR→RUN only via reset.
- In ERR: pc_out, npc_out and annul_out hold; err=1.
- RUN with en=0: all registers hold, annul_out included.
- RUN with en=1, one update per cycle, zero extra latency (new values visible the cycle after the edge):
  - pc_out <= npc_out (delay-slot semantics, always).
  - npc_out <= target, where target is:
    - 00, or 01 with branch_taken=0: npc4_in.
    - 01 with branch_taken=1: pc_out + (sext(disp22)<<2).
    - 10: pc_out + (sext(disp30)<<2).
    - 11: jmpl_addr.
  - annul_out <= annul_req. It stays asserted for exactly the instruction now moving into PC and clears on the next enabled update unless re-requested.
- Misaligned jmpl: pc_src=11, en=1 and jmpl_addr[1:0]!=0.
  - No register update; state→ERR, err=1 from the next cycle.
  - Misalignment is ignored when en=0.
- Arithmetic:
  - All sums are 32-bit modulo 2^32; wrap-around is silent (e.g. 0xFFFF_FFFC+4 → 0).
  - Branch and call targets are always word-aligned by construction.
- pc_src=01 with branch_taken=0 and annul_req=1: the fall-through delay slot is annulled. This is the normal "not-taken, a=1" case; no special handling.
- The block does not check npc4_in; the adder's correctness is its own concern.

Decomposition:
- Shared package:
  - pc_src encodings (PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_CALL=2'b10, PCSRC_JMPL=2'b11).
  - State encoding (ST_RUN, ST_ERR).
  - Default reset-vector constant.
- One natural sub-module: `pc_target_mux`. It is combinational and holds the sign-extension, shift, add and 4-way select, with the misalign flag as an output.
- The top level keeps the registers and the FSM.

Test Plan:
- Reset then 3 enabled sequential cycles, with the bench modelling the adder (npc4_in=npc_out+4) → pc_out 0,4,8,12; npc_out 4,8,12,16; annul_out=0; err=0.
- At pc_out=0x10 (npc=0x14), assert pc_src=01, branch_taken=1, disp22=-2 (0x3FFFFE) → next cycle pc_out=0x14 (delay slot), npc_out=0x08; following cycle pc_out=0x08.
- At pc_out=0x100, assert pc_src=10, disp30=0x40 → next npc_out=0x200. Separately, at pc_out=0xFFFF_FFF0, disp30=0x8 → npc_out=0x0000_0010 (wrap).
- Assert pc_src=11 with jmpl_addr=0x1002 → err=1 next cycle; pc_out and npc_out frozen for ≥5 cycles regardless of inputs. Then rst=0 for one cycle → pc_out=0, npc_out=4, err=0.
- Hold en=0 for 3 cycles with pc_src=11 and jmpl_addr=0x3 → no change, err stays 0. Then en=1, pc_src=00 → normal advance.
- Assert annul_req=1 with pc_src=01, branch_taken=0 at pc_out=0x20 → next cycle pc_out=0x24 with annul_out=1. Next enabled cycle annul_out=0. Additionally, stall (en=0) during annul_out=1 → annul_out holds 1.
